// File: rtl/draw_ctrl.sv
// Drawing controller: clears the frame buffer, then hands off to the circle engine,
// merging both pixel sources into one registered, clipped VGA pixel stream.
module draw_ctrl #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int CLEAR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    output logic       done,
    output logic       circ_start,
    input  logic       circ_done,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {IDLE, CLEAR, CIRCLE, DONE} state_t;

    localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    state_t     state_q, state_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [2:0] col_q, col_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;

    logic       pix_vld;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_col;
    logic       circ_in_frame;

    // Zero-extended so the clip test stays correct at the full 8/7-bit input range.
    assign circ_in_frame = ({1'b0, circ_x} < X_LIM) && ({1'b0, circ_y} < Y_LIM);

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        col_d      = col_q;
        pix_vld    = 1'b0;
        pix_x      = cx_q;
        pix_y      = cy_q;
        pix_col    = 3'd0;
        done       = 1'b0;
        circ_start = 1'b0;

        case (state_q)
            IDLE: begin
                cx_d = 8'd0;
                cy_d = 7'd0;
                if (start) begin
                    col_d   = colour;
                    state_d = (CLEAR_EN != 0) ? CLEAR : CIRCLE;
                end
            end
            CLEAR: begin
                // Dropping start abandons the pass; nothing is generated in that cycle.
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    pix_vld = 1'b1;
                    if (cy_q == Y_LAST) begin
                        cy_d = 7'd0;
                        if (cx_q == X_LAST) begin
                            cx_d    = 8'd0;
                            state_d = CIRCLE;
                        end else begin
                            cx_d = cx_q + 8'd1;
                        end
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end
            end
            CIRCLE: begin
                circ_start = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    pix_vld = circ_plot && circ_in_frame;
                    pix_x   = circ_x;
                    pix_y   = circ_y;
                    pix_col = col_q;
                    if (circ_done) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vga_plot_d   = pix_vld;
        vga_x_d      = pix_vld ? pix_x   : vga_x_q;
        vga_y_d      = pix_vld ? pix_y   : vga_y_q;
        vga_colour_d = pix_vld ? pix_col : vga_colour_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cx_q         <= 8'd0;
            cy_q         <= 7'd0;
            col_q        <= 3'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            col_q        <= col_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule
